// File: rtl/tape_pkg.sv
// Shared types, defaults and helpers for the cassette read-path detector.
package tape_pkg;

    typedef logic signed [15:0] tape_sample_t;

    localparam int          HYST_DEFAULT      = 1024;
    localparam int unsigned MIN_PULSE_DEFAULT = 4;
    localparam int unsigned DC_SHIFT_DEFAULT  = 8;

    // Signed add of two 17-bit operands, clamped to the 16-bit sample range.
    function automatic tape_sample_t sat_add(input logic signed [16:0] a,
                                             input logic signed [16:0] b);
        logic signed [17:0] sum;
        sum = 18'(a) + 18'(b);
        if (sum > 18'sd32767) begin
            return 16'sh7fff;
        end else if (sum < -18'sd32768) begin
            return 16'sh8000;
        end
        return sum[15:0];
    endfunction

endpackage

// File: rtl/tape_dc_block.sv
// DC tracker: fractional running mean of the input and the saturated
// mean-removed sample. The accumulator holds dc scaled by 2^DC_SHIFT, so
// adding the raw difference equals dc += diff >>> DC_SHIFT with the fraction kept.
module tape_dc_block
    import tape_pkg::*;
#(
    parameter int unsigned DC_SHIFT = DC_SHIFT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [15:0] i_x,
    output logic [15:0] o_y
);

    localparam int unsigned ACC_W = 16 + DC_SHIFT;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [15:0]      w_dc;
    logic signed [16:0]      w_x17;
    logic signed [16:0]      w_dc17;
    logic signed [16:0]      w_diff;

    assign w_dc   = 16'(r_acc >>> DC_SHIFT);
    assign w_x17  = 17'($signed(i_x));
    assign w_dc17 = 17'(w_dc);
    assign w_diff = w_x17 - w_dc17;
    assign o_y    = sat_add(w_x17, -w_dc17);

    // Accumulate the unsaturated difference; motor-off clears the tracker.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + ACC_W'(w_diff);
        end
    end

endmodule

// File: rtl/tape_zero_cross.sv
// Cassette zero-cross detector: optional DC removal, hysteresis comparator,
// minimum-pulse glitch filter and half-period measurement.
// Build option: define TAPE_ZC_DCBLOCK_EN to include the DC tracker.
module tape_zero_cross
    import tape_pkg::*;
#(
    parameter int          HYST         = HYST_DEFAULT,
    parameter int unsigned MIN_PULSE    = MIN_PULSE_DEFAULT,
    parameter int unsigned DC_SHIFT     = DC_SHIFT_DEFAULT,
    parameter int unsigned PERIOD_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_3mhz_en,
    input  logic [0:15]             tape_audio,
    input  logic                    cs1_cntrl,
    output logic                    mag_in,
    output logic                    edge_strobe,
    output logic [0:PERIOD_WIDTH-1] last_period
);

    if (MIN_PULSE < 1 || MIN_PULSE > 15) begin : g_bad_min_pulse
        $error("MIN_PULSE must be in 1..15");
    end
    if (DC_SHIFT < 4 || DC_SHIFT > 12) begin : g_bad_dc_shift
        $error("DC_SHIFT must be in 4..12");
    end

    localparam tape_sample_t HYST_POS = tape_sample_t'(HYST);
    localparam tape_sample_t HYST_NEG = tape_sample_t'(-HYST);
    localparam logic [3:0]   CNT_HIT  = 4'(MIN_PULSE);

    tape_sample_t            w_x;
    tape_sample_t            w_y_next;
    tape_sample_t            r_y;
    logic                    r_mag;
    logic                    r_strobe;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_inc;
    logic [PERIOD_WIDTH-1:0] r_per;
    logic [PERIOD_WIDTH-1:0] w_per_inc;
    logic [PERIOD_WIDTH-1:0] r_last;
    logic                    w_cond;
    logic                    w_toggle;

    // Leftmost port bit is the sample MSB, so a plain assignment keeps the value.
    assign w_x = tape_audio;

`ifdef TAPE_ZC_DCBLOCK_EN
    logic [15:0] w_dc_y;

    tape_dc_block #(
        .DC_SHIFT(DC_SHIFT)
    ) u_dc_block (
        .clk   (clk),
        .reset (reset),
        .i_clr (~cs1_cntrl),
        .i_en  (clk_3mhz_en),
        .i_x   (w_x),
        .o_y   (w_dc_y)
    );

    assign w_y_next = w_dc_y;
`else
    assign w_y_next = w_x;
`endif

    // Comparator threshold depends on the current level (hysteresis).
    always_comb begin
        w_cond    = r_mag ? (r_y < HYST_NEG) : (r_y > HYST_POS);
        w_cnt_inc = r_cnt + 4'd1;
        w_toggle  = w_cond && (w_cnt_inc == CNT_HIT);
        w_per_inc = (&r_per) ? r_per : r_per + PERIOD_WIDTH'(1);
    end

    // Sample, filter and period state; motor-off forces a quiet restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_y      <= '0;
            r_mag    <= 1'b0;
            r_strobe <= 1'b0;
            r_cnt    <= '0;
            r_per    <= '0;
            r_last   <= '0;
        end else if (!cs1_cntrl) begin
            r_y      <= '0;
            r_mag    <= 1'b0;
            r_strobe <= 1'b0;
            r_cnt    <= '0;
            r_per    <= '0;
        end else begin
            r_strobe <= 1'b0;
            if (clk_3mhz_en) begin
                r_y <= w_y_next;
                if (w_toggle) begin
                    r_mag    <= ~r_mag;
                    r_strobe <= 1'b1;
                    r_cnt    <= '0;
                    r_per    <= '0;
                    r_last   <= w_per_inc;
                end else begin
                    r_cnt <= w_cond ? w_cnt_inc : 4'd0;
                    r_per <= w_per_inc;
                end
            end
        end
    end

    assign mag_in      = r_mag;
    assign edge_strobe = r_strobe;
    assign last_period = r_last;

endmodule

// File: tb/tb_tape_zero_cross.sv
// Self-checking bench for tape_zero_cross: directed scenarios plus a random
// run against an event-level reference model (enable indices between toggles).
module tb_tape_zero_cross;

    localparam int HYST      = 1024;
    localparam int MIN_PULSE = 4;
    localparam int PW        = 12;
    localparam int PER_MAX   = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_3mhz_en;
    logic [0:15]   tape_audio;
    logic          cs1_cntrl;
    logic          mag_in;
    logic          edge_strobe;
    logic [0:PW-1] last_period;

    always #5 clk = ~clk;

    tape_zero_cross #(
        .HYST         (HYST),
        .MIN_PULSE    (MIN_PULSE),
        .DC_SHIFT     (8),
        .PERIOD_WIDTH (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_3mhz_en (clk_3mhz_en),
        .tape_audio  (tape_audio),
        .cs1_cntrl   (cs1_cntrl),
        .mag_in      (mag_in),
        .edge_strobe (edge_strobe),
        .last_period (last_period)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: level, qualifying-run length, enable index since restart.
    bit m_mag;
    bit m_strobe;
    int m_run;
    int m_prev;
    int m_idx;
    int m_last_idx;
    int m_last;

    // Drive one clk with the given inputs, then advance the model.
    task automatic cyc(input bit rst, input bit en, input logic [15:0] s, input bit motor);
        reset       = rst;
        clk_3mhz_en = en;
        tape_audio  = s;
        cs1_cntrl   = motor;
        @(posedge clk);
        #1;
        m_strobe = 1'b0;
        if (rst || !motor) begin
            m_mag      = 1'b0;
            m_run      = 0;
            m_prev     = 0;
            m_idx      = 0;
            m_last_idx = 0;
            if (rst) m_last = 0;
        end else if (en) begin
            m_idx++;
            // The level flips once the sample seen at the previous enable has
            // been beyond the opposite threshold for MIN_PULSE enables running.
            if (m_mag ? (m_prev < -HYST) : (m_prev > HYST)) m_run++;
            else m_run = 0;
            if (m_run == MIN_PULSE) begin
                m_mag      = !m_mag;
                m_run      = 0;
                m_strobe   = 1'b1;
                m_last     = (m_idx - m_last_idx > PER_MAX) ? PER_MAX : m_idx - m_last_idx;
                m_last_idx = m_idx;
            end
            m_prev = int'($signed(s));
        end
    endtask

    task automatic test_reset();
        cyc(1, 0, 16'h0000, 1);
        cyc(1, 1, 16'h4000, 1);
        n_cmp++;
        if (mag_in !== 1'b0) begin
            n_bad++; $display("FAIL reset_mag: got %b want 0", mag_in);
        end
        n_cmp++;
        if (edge_strobe !== 1'b0) begin
            n_bad++; $display("FAIL reset_strobe: got %b want 0", edge_strobe);
        end
        n_cmp++;
        if (last_period !== 12'd0) begin
            n_bad++; $display("FAIL reset_last: got %0d want 0", last_period);
        end
    endtask

    task automatic test_step();
        cyc(0, 0, 16'h0000, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'h0000, 1);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 16'h4000, 1);
            n_cmp++;
            if (mag_in !== (i >= 5)) begin
                n_bad++; $display("FAIL step_mag[%0d]: got %b want %b", i, mag_in, i >= 5);
            end
            n_cmp++;
            if (edge_strobe !== (i == 5)) begin
                n_bad++;
                $display("FAIL step_strobe[%0d]: got %b want %b", i, edge_strobe, i == 5);
            end
            if (i == 5) begin
                n_cmp++;
                if (last_period !== 12'd9) begin
                    n_bad++; $display("FAIL step_last: got %0d want 9", last_period);
                end
            end
            cyc(0, 0, 16'h4000, 1);
            n_cmp++;
            if (edge_strobe !== 1'b0) begin
                n_bad++; $display("FAIL step_strobe_width[%0d]: got %b want 0", i, edge_strobe);
            end
        end
    endtask

    task automatic test_square();
        int edges = 0;
        cyc(0, 0, 16'h0000, 0);
        for (int h = 0; h < 5; h++) begin
            for (int i = 0; i < 700; i++) begin
                cyc(0, 1, (h % 2 == 0) ? 16'h4000 : 16'hC000, 1);
                if (edge_strobe === 1'b1) begin
                    edges++;
                    n_cmp++;
                    if (mag_in !== 1'((edges % 2) == 1)) begin
                        n_bad++; $display("FAIL square_mag[%0d]: got %b", edges, mag_in);
                    end
                    if (edges >= 2) begin
                        n_cmp++;
                        if (last_period !== 12'd700) begin
                            n_bad++;
                            $display("FAIL square_last[%0d]: got %0d want 700", edges, last_period);
                        end
                    end
                end
            end
        end
        n_cmp++;
        if (edges != 5) begin
            n_bad++; $display("FAIL square_edges: got %0d want 5", edges);
        end
    endtask

    task automatic test_glitch();
        int strobes = 0;
        cyc(0, 0, 16'h0000, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'h0000, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'h4000, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 16'h0000, 1);
            if (edge_strobe === 1'b1) strobes++;
        end
        n_cmp++;
        if (mag_in !== 1'b0 || strobes != 0) begin
            n_bad++; $display("FAIL glitch: mag %b strobes %0d want 0 and 0", mag_in, strobes);
        end
    endtask

    task automatic test_hyst();
        int strobes = 0;
        cyc(0, 0, 16'h0000, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 16'h0400, 1);
            if (edge_strobe === 1'b1) strobes++;
        end
        n_cmp++;
        if (mag_in !== 1'b0 || strobes != 0) begin
            n_bad++; $display("FAIL hyst_at_thresh: mag %b strobes %0d want 0", mag_in, strobes);
        end
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 16'h0401, 1);
            n_cmp++;
            if (mag_in !== (i >= 5)) begin
                n_bad++; $display("FAIL hyst_rise[%0d]: got %b want %b", i, mag_in, i >= 5);
            end
        end
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 16'hFD00, 1);
            if (edge_strobe === 1'b1) strobes++;
        end
        n_cmp++;
        if (mag_in !== 1'b1 || strobes != 0) begin
            n_bad++; $display("FAIL hyst_hold: mag %b strobes %0d want 1 and 0", mag_in, strobes);
        end
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1, 16'hFBFF, 1);
            n_cmp++;
            if (mag_in !== (i < 5)) begin
                n_bad++; $display("FAIL hyst_fall[%0d]: got %b want %b", i, mag_in, i < 5);
            end
        end
    endtask

    task automatic test_motor_off();
        int saved;
        cyc(0, 0, 16'h0000, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 16'h4000, 1);
        saved = m_last;
        cyc(0, 0, 16'h4000, 0);
        n_cmp++;
        if (mag_in !== 1'b0 || edge_strobe !== 1'b0) begin
            n_bad++; $display("FAIL motor_off: mag %b strobe %b want 0 0", mag_in, edge_strobe);
        end
        n_cmp++;
        if (last_period !== 12'(saved)) begin
            n_bad++; $display("FAIL motor_off_last: got %0d want %0d", last_period, saved);
        end
        // Motor drops on the enable that would have toggled.
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'h4000, 1);
        cyc(0, 1, 16'h4000, 0);
        n_cmp++;
        if (mag_in !== 1'b0 || edge_strobe !== 1'b0) begin
            n_bad++; $display("FAIL motor_race: mag %b strobe %b want 0 0", mag_in, edge_strobe);
        end
        // Reset part way through a qualifying run.
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'h4000, 1);
        cyc(1, 1, 16'h4000, 1);
        n_cmp++;
        if (mag_in !== 1'b0 || edge_strobe !== 1'b0 || last_period !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_mid: mag %b strobe %b last %0d want 0 0 0",
                     mag_in, edge_strobe, last_period);
        end
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 1, 16'h4000, 1);
            n_cmp++;
            if (mag_in !== (i == 5)) begin
                n_bad++; $display("FAIL reset_restart[%0d]: got %b want %b", i, mag_in, i == 5);
            end
        end
    endtask

    task automatic test_saturation();
        cyc(0, 0, 16'h0000, 0);
        for (int i = 0; i < 5000; i++) cyc(0, 1, 16'h0000, 1);
        for (int i = 1; i <= 5; i++) cyc(0, 1, 16'h4000, 1);
        n_cmp++;
        if (edge_strobe !== 1'b1 || last_period !== 12'hFFF) begin
            n_bad++;
            $display("FAIL saturation: strobe %b last %h want 1 fff", edge_strobe, last_period);
        end
    endtask

    task automatic test_random();
        logic [15:0] pick;
        int          hold = 0;
        int          bad_here = 0;
        cyc(0, 0, 16'h0000, 0);
        pick = 16'h0000;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 7);
                case ($urandom_range(0, 6))
                    0: pick = 16'h4000;
                    1: pick = 16'hC000;
                    2: pick = 16'h0400;
                    3: pick = 16'h0401;
                    4: pick = 16'hFBFF;
                    5: pick = 16'hFC00;
                    default: pick = 16'($urandom);
                endcase
            end
            hold--;
            cyc($urandom_range(0, 999) == 0, $urandom_range(0, 3) != 0, pick,
                $urandom_range(0, 299) != 0);
            n_cmp++;
            if (mag_in !== m_mag || edge_strobe !== m_strobe || last_period !== 12'(m_last)) begin
                n_bad++;
                if (bad_here < 10)
                    $display("FAIL random[%0d]: mag %b strobe %b last %0d want %b %b %0d",
                             c, mag_in, edge_strobe, last_period, m_mag, m_strobe, m_last);
                bad_here++;
            end
        end
    endtask

    task automatic test_dc_block();
        int strobes = 0;
        cyc(0, 0, 16'h0000, 0);
        for (int i = 0; i < 3000; i++) begin
            cyc(0, 1, 16'h2000, 1);
            if (edge_strobe === 1'b1) strobes++;
        end
        n_cmp++;
        if (strobes != 1) begin
            n_bad++; $display("FAIL dc_strobes: got %0d want 1", strobes);
        end
        n_cmp++;
        if (mag_in !== 1'b1) begin
            n_bad++; $display("FAIL dc_level: got %b want 1", mag_in);
        end
    endtask

    initial begin
        reset       = 1'b1;
        clk_3mhz_en = 1'b0;
        tape_audio  = 16'h0000;
        cs1_cntrl   = 1'b0;
        m_mag = 0; m_strobe = 0; m_run = 0; m_prev = 0;
        m_idx = 0; m_last_idx = 0; m_last = 0;
        test_reset();
`ifdef TAPE_ZC_DCBLOCK_EN
        test_dc_block();
`else
        test_step();
        test_square();
        test_glitch();
        test_hyst();
        test_motor_off();
        test_saturation();
        test_random();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
